hello_scroll_ctrl: RTL and testbench

//  Sequencer that scrolls the letter-code message "HELLO" across NUM_DIGITS display digits.

---
 rtl/hello_pkg.sv | 35 +++
 rtl/hello_scroll_ctrl_prescaler.sv | 29 ++
 rtl/hello_scroll_ctrl.sv | 112 +++++++++++
 tb/tb_hello_scroll_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hello_pkg.sv
// Shared letter encoding, message contents and scroll FSM states for the
// HELLO scroller.
package hello_pkg;

   typedef enum logic [2:0] {
      BLANK = 3'b000,
      H     = 3'b001,
      E     = 3'b010,
      L     = 3'b011,
      O     = 3'b100
   } letter_t;

   localparam int MSG_LEN = 5;
   localparam letter_t MESSAGE [MSG_LEN] = '{H, E, L, L, O};

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SCROLL = 2'd1,
      PAUSE  = 2'd2
   } scroll_state_t;

   // Indices past the message feed blanks so the text scrolls fully off.
   function automatic letter_t feed_letter(input int unsigned idx);
      letter_t res;
      case (idx)
         0:       res = H;
         1:       res = E;
         2, 3:    res = L;
         4:       res = O;
         default: res = BLANK;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/hello_scroll_ctrl_prescaler.sv
// Step prescaler: counts 0..TICK_DIV-1 while enabled; wrap flags the count
// value on which the next enabled edge wraps to zero (a scroll step).
module scroll_prescaler #(
   parameter int TICK_DIV = 25_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic wrap
);

   localparam int PW = $clog2(TICK_DIV);

   logic [PW-1:0] count;

   assign wrap = (count == PW'(TICK_DIV - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en) begin
         count <= wrap ? '0 : count + 1'b1;
      end
   end

endmodule

// File: rtl/hello_scroll_ctrl.sv
// Scrolls "HELLO" across NUM_DIGITS letter-code digits, one letter per
// TICK_DIV clocks, with start/stop/pause and continuous loop.
module hello_scroll_ctrl
   import hello_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int TICK_DIV   = 25_000_000
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic                    stop,
   input  logic                    pause,
   input  logic                    loop,
   output logic [3*NUM_DIGITS-1:0] digits,
   output logic                    busy,
   output logic                    done,
   output logic [1:0]              fsm_state
);

   localparam int STEPS = MSG_LEN + NUM_DIGITS;
   localparam int IW    = $clog2(STEPS + 1);

   // Handshake-free control: start/stop/pause/loop are plain levels sampled
   // on every posedge; outputs change only on posedge or async reset.
   scroll_state_t             state, state_n;
   logic [IW-1:0]             index, index_n;
   logic [3*NUM_DIGITS-1:0]   digits_n;
   logic                      done_n;
   logic                      pre_en, pre_clr, pre_wrap;

   scroll_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
      .clk  (clk),
      .rst  (rst),
      .en   (pre_en),
      .clr  (pre_clr),
      .wrap (pre_wrap)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         index  <= '0;
         digits <= '0;
         done   <= 1'b0;
      end else begin
         state  <= state_n;
         index  <= index_n;
         digits <= digits_n;
         done   <= done_n;
      end
   end

   always_comb begin
      state_n  = state;
      index_n  = index;
      digits_n = digits;
      done_n   = 1'b0;
      pre_en   = 1'b0;
      pre_clr  = 1'b0;

      if (stop) begin
         state_n  = IDLE;
         index_n  = '0;
         digits_n = '0;
         pre_clr  = 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state_n  = SCROLL;
                  index_n  = '0;
                  digits_n = '0;
                  pre_clr  = 1'b1;
               end
            end
            SCROLL, PAUSE: begin
               if (pause) begin
                  state_n = PAUSE;
               end else begin
                  // Leaving PAUSE counts on the same edge, resuming the held value.
                  state_n = SCROLL;
                  pre_en  = 1'b1;
                  if (pre_wrap) begin
                     for (int i = NUM_DIGITS - 1; i > 0; i--) begin
                        digits_n[3*i +: 3] = digits[3*(i-1) +: 3];
                     end
                     digits_n[2:0] = feed_letter(32'(index));
                     if (index == IW'(STEPS - 1)) begin
                        index_n = '0;
                        if (!loop) begin
                           state_n  = IDLE;
                           done_n   = 1'b1;
                           digits_n = '0;
                        end
                     end else begin
                        index_n = index + 1'b1;
                     end
                  end
               end
            end
            default: begin
               state_n = IDLE;
            end
         endcase
      end
   end

   assign busy      = (state != IDLE);
   assign fsm_state = state;

endmodule

// File: tb/tb_hello_scroll_ctrl.sv
// Directed bench for hello_scroll_ctrl with NUM_DIGITS=4, TICK_DIV=4;
// t counts edges after the Start-accepting edge.
module tb_hello_scroll_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        start, stop, pause, loop;
   logic [11:0] digits;
   logic        busy, done;
   logic [1:0]  fsm_state;

   int checks = 0;
   int errors = 0;
   int t = 0;

   hello_scroll_ctrl #(.NUM_DIGITS(4), .TICK_DIV(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .stop      (stop),
      .pause     (pause),
      .loop      (loop),
      .digits    (digits),
      .busy      (busy),
      .done      (done),
      .fsm_state (fsm_state)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
      t++;
   endtask

   // Advance to edge target, recording whether done was ever seen high.
   task automatic run_to(input int target, output logic done_seen);
      done_seen = 1'b0;
      while (t < target) begin
         tick();
         done_seen = done_seen | done;
      end
   endtask

   task automatic start_pass(input logic lp);
      loop  = lp;
      start = 1'b1;
      tick();
      start = 1'b0;
      t = 0;
   endtask

   task automatic abort();
      stop = 1'b1;
      tick();
      stop = 1'b0;
   endtask

   task automatic test_reset();
      checks++;
      if (digits !== 12'h000 || busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL reset_state digits=%h busy=%b done=%b need 000/0/0", digits, busy, done);
      end
   endtask

   task automatic test_single_pass();
      logic ds;
      start_pass(1'b0);
      run_to(1, ds);
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL pass_busy t=1 got %b need 1", busy); end
      run_to(3, ds);
      checks++;
      if (digits !== 12'h000) begin errors++; $display("FAIL pass_t3 got %h need 000", digits); end
      run_to(4, ds);
      checks++;
      if (digits !== 12'h001) begin errors++; $display("FAIL pass_t4 got %h need 001", digits); end
      run_to(16, ds);
      checks++;
      if (digits !== 12'h29b) begin errors++; $display("FAIL pass_t16 got %h need 29b", digits); end
      run_to(20, ds);
      checks++;
      if (digits !== 12'h4dc) begin errors++; $display("FAIL pass_t20 got %h need 4dc", digits); end
      run_to(35, ds);
      checks++;
      if (ds !== 1'b0 || busy !== 1'b1) begin
         errors++; $display("FAIL pass_early_done done_seen=%b busy=%b need 0/1", ds, busy);
      end
      run_to(36, ds);
      checks++;
      if (digits !== 12'h000 || done !== 1'b1) begin
         errors++; $display("FAIL pass_t36 digits=%h done=%b need 000/1", digits, done);
      end
      run_to(37, ds);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL pass_t37 done=%b busy=%b need 0/0", done, busy);
      end
   endtask

   task automatic test_loop();
      logic ds;
      start_pass(1'b1);
      run_to(36, ds);
      checks++;
      if (ds !== 1'b0 || busy !== 1'b1 || digits !== 12'h000) begin
         errors++;
         $display("FAIL loop_t36 done_seen=%b busy=%b digits=%h need 0/1/000", ds, busy, digits);
      end
      run_to(40, ds);
      checks++;
      if (digits !== 12'h001 || busy !== 1'b1) begin
         errors++; $display("FAIL loop_t40 digits=%h busy=%b need 001/1", digits, busy);
      end
      run_to(44, ds);
      checks++;
      if (digits !== 12'h00a) begin errors++; $display("FAIL loop_t44 got %h need 00a", digits); end
      abort();
   endtask

   task automatic test_pause();
      logic ds;
      start_pass(1'b0);
      run_to(4, ds);
      pause = 1'b1;
      run_to(14, ds);
      checks++;
      if (digits !== 12'h001 || fsm_state !== 2'd2 || busy !== 1'b1) begin
         errors++;
         $display("FAIL pause_hold digits=%h state=%0d busy=%b need 001/2/1", digits, fsm_state, busy);
      end
      pause = 1'b0;
      run_to(17, ds);
      checks++;
      if (digits !== 12'h001) begin errors++; $display("FAIL pause_t17 got %h need 001", digits); end
      run_to(18, ds);
      checks++;
      if (digits !== 12'h00a) begin errors++; $display("FAIL pause_t18 got %h need 00a", digits); end
      abort();
   endtask

   task automatic test_stop();
      logic ds;
      start_pass(1'b0);
      run_to(10, ds);
      stop = 1'b1;
      run_to(11, ds);
      stop = 1'b0;
      checks++;
      if (digits !== 12'h000 || busy !== 1'b0 || done !== 1'b0) begin
         errors++; $display("FAIL stop_t11 digits=%h busy=%b done=%b need 000/0/0", digits, busy, done);
      end
      run_to(40, ds);
      checks++;
      if (ds !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL stop_after done_seen=%b busy=%b need 0/0", ds, busy);
      end
      start = 1'b1;
      stop  = 1'b1;
      tick();
      tick();
      start = 1'b0;
      stop  = 1'b0;
      checks++;
      if (busy !== 1'b0 || digits !== 12'h000) begin
         errors++; $display("FAIL start_stop busy=%b digits=%h need 0/000", busy, digits);
      end
   endtask

   task automatic test_start_ignored();
      logic ds;
      start_pass(1'b0);
      run_to(5, ds);
      start = 1'b1;
      run_to(6, ds);
      start = 1'b0;
      run_to(8, ds);
      checks++;
      if (digits !== 12'h00a) begin errors++; $display("FAIL ign_t8 got %h need 00a", digits); end
      run_to(20, ds);
      checks++;
      if (digits !== 12'h4dc) begin errors++; $display("FAIL ign_t20 got %h need 4dc", digits); end
      run_to(36, ds);
      checks++;
      if (done !== 1'b1 || digits !== 12'h000) begin
         errors++; $display("FAIL ign_t36 done=%b digits=%h need 1/000", done, digits);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      logic ds;
      start_pass(1'b0);
      start = 1'b1;
      run_to(36, ds);
      checks++;
      if (done !== 1'b1) begin errors++; $display("FAIL b2b_done got %b need 1", done); end
      run_to(37, ds);
      start = 1'b0;
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
         errors++; $display("FAIL b2b_restart busy=%b done=%b need 1/0", busy, done);
      end
      run_to(41, ds);
      checks++;
      if (digits !== 12'h001) begin errors++; $display("FAIL b2b_t41 got %h need 001", digits); end
      abort();
   endtask

   task automatic test_async_reset();
      logic ds;
      start_pass(1'b0);
      run_to(8, ds);
      #3;
      rst = 1'b1;
      #1;
      checks++;
      if (digits !== 12'h000 || busy !== 1'b0 || done !== 1'b0) begin
         errors++; $display("FAIL async_rst digits=%h busy=%b done=%b need 000/0/0", digits, busy, done);
      end
      #10;
      rst = 1'b0;
      run_to(20, ds);
      checks++;
      if (busy !== 1'b0 || digits !== 12'h000 || ds !== 1'b0) begin
         errors++;
         $display("FAIL post_rst busy=%b digits=%h done_seen=%b need 0/000/0", busy, digits, ds);
      end
   endtask

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      stop  = 1'b0;
      pause = 1'b0;
      loop  = 1'b0;
      #12;
      test_reset();
      rst = 1'b0;
      tick();
      test_single_pass();
      test_loop();
      test_pause();
      test_stop();
      test_start_ignored();
      test_back_to_back();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
